// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } sched_state_t;

endpackage

// File: rtl/uart_rr_arb.sv
// Combinational round-robin picker: first requester after last_i, with wrap.
module uart_rr_arb #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   last_i,
  input  logic            en_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  // Scan (last+1) .. (last+NREQ) mod NREQ and take the first set request.
  always_comb begin
    int unsigned cand;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = 0;
    if (en_i) begin
      for (int unsigned k = 1; k <= NREQ; k++) begin
        cand = (32'(last_i) + k) % NREQ;
        if (!any_o && req_i[IW'(cand)]) begin
          any_o              = 1'b1;
          gnt_o[IW'(cand)]   = 1'b1;
          idx_o              = IW'(cand);
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx between NREQ byte streams,
// with packet locking and a watchdog for stuck serializer / stalled requester.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TMO_CYC = 200000,
  parameter int unsigned TMO_W   = 20
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*BYTE_W-1:0]   req_data,
  input  logic [NREQ-1:0]          req_last,
  output logic [NREQ-1:0]          req_ready,
  output logic                     tx_start,
  output logic [BYTE_W-1:0]        din,
  input  logic                     tx_done_tck,
  output logic                     busy,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     tmo_err
);

  localparam int unsigned IW = $clog2(NREQ);

  sched_state_t             state_q, state_d;
  logic [BYTE_W-1:0]        din_q, din_d;
  logic [IW-1:0]            grant_q, grant_d;
  logic [IW-1:0]            last_q, last_d;
  logic                     lock_q, lock_d;
  logic                     lock_nx_q, lock_nx_d;
  logic [TMO_W-1:0]         wd_q, wd_d;
  logic                     tmo_q, tmo_d;

  logic [NREQ-1:0][BYTE_W-1:0] data_arr;
  logic [NREQ-1:0]          arb_req;
  logic [NREQ-1:0]          arb_gnt;
  logic [IW-1:0]            arb_idx;
  logic                     arb_any;
  logic                     wd_at_lim;
  logic [TMO_W-1:0]         wd_inc;

  assign data_arr = req_data;

  // While locked only the current owner may be picked.
  assign arb_req = lock_q ? (req_valid & (NREQ'(1) << grant_q)) : req_valid;

  uart_rr_arb #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req_i  (arb_req),
    .last_i (last_q),
    .en_i   ((state_q == IDLE) && !reset),
    .gnt_o  (arb_gnt),
    .idx_o  (arb_idx),
    .any_o  (arb_any)
  );

  assign wd_at_lim = (TMO_CYC != 0) && (wd_q == TMO_W'(TMO_CYC - 1));
  assign wd_inc    = (wd_q == '1) ? wd_q : wd_q + 1'b1;

  // Next-state, accept and watchdog decisions.
  always_comb begin
    state_d   = state_q;
    din_d     = din_q;
    grant_d   = grant_q;
    last_d    = last_q;
    lock_d    = lock_q;
    lock_nx_d = lock_nx_q;
    wd_d      = wd_q;
    tmo_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          din_d     = data_arr[arb_idx];
          grant_d   = arb_idx;
          lock_nx_d = !req_last[arb_idx];
          state_d   = START;
          wd_d      = '0;
        end else if (lock_q) begin
          if (wd_at_lim) begin
            tmo_d  = 1'b1;
            lock_d = 1'b0;
            last_d = grant_q;
            wd_d   = '0;
          end else begin
            wd_d = wd_inc;
          end
        end
      end
      START: begin
        state_d = WAIT;
        wd_d    = '0;
      end
      WAIT: begin
        // done is checked first so it wins over a same-cycle expiry
        if (tx_done_tck) begin
          last_d  = grant_q;
          lock_d  = lock_nx_q;
          state_d = IDLE;
          wd_d    = '0;
        end else if (wd_at_lim) begin
          tmo_d   = 1'b1;
          lock_d  = 1'b0;
          last_d  = grant_q;
          state_d = IDLE;
          wd_d    = '0;
        end else begin
          wd_d = wd_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      din_q     <= '0;
      grant_q   <= '0;
      last_q    <= IW'(NREQ - 1);
      lock_q    <= 1'b0;
      lock_nx_q <= 1'b0;
      wd_q      <= '0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      din_q     <= din_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      lock_q    <= lock_d;
      lock_nx_q <= lock_nx_d;
      wd_q      <= wd_d;
      tmo_q     <= tmo_d;
    end
  end

  assign req_ready = arb_gnt;
  assign tx_start  = (state_q == START);
  assign busy      = (state_q != IDLE);
  assign din       = din_q;
  assign grant_id  = grant_q;
  assign tmo_err   = tmo_q;

endmodule
